// File: rtl/lt_pkg.sv
// Shared definitions for the signed less-than result packing datapath.
package lt_pkg;

    // Default number of comparison results packed into one predicate word.
    localparam int LT_MASK_WIDTH = 16;

    // Packer states: accumulating results, or presenting a closed word.
    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } lt_state_e;

    // Width needed to hold a count in the range 0..w inclusive.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/lt_mask_packer.sv
// Packs 1-bit signed-compare results into a predicate mask word. It also keeps
// a running popcount and a valid-bit count, and hands each closed word
// downstream over a valid/ready handshake. A word can be released and a new
// word started on the same cycle, so one result per cycle is sustained.
module lt_mask_packer
    import lt_pkg::*;
#(
    parameter int MASK_WIDTH = LT_MASK_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic                                   in_y,
    input  logic                                   in_last,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [MASK_WIDTH-1:0]                  out_mask,
    output logic [cnt_width(MASK_WIDTH)-1:0]       out_count,
    output logic [cnt_width(MASK_WIDTH)-1:0]       out_nbits,
    output logic                                   out_last
);

    localparam int CNT_WIDTH = cnt_width(MASK_WIDTH);
    localparam int IDX_WIDTH = $clog2(MASK_WIDTH);

    lt_state_e               state_q, state_d;
    logic [IDX_WIDTH-1:0]    idx_q,   idx_d;
    logic [MASK_WIDTH-1:0]   mask_q,  mask_d;
    logic [CNT_WIDTH-1:0]    count_q, count_d;
    logic [CNT_WIDTH-1:0]    nbits_q, nbits_d;
    logic                    last_q,  last_d;

    logic                    accept_s;
    logic                    at_top_s;
    logic [CNT_WIDTH-1:0]    y_ext_s;

    // Accept a beat while filling, or while the held word leaves this cycle.
    always_comb begin
        in_ready = (state_q == FILL) || ((state_q == HOLD) && out_ready);
        accept_s = in_valid && in_ready;
        at_top_s = (idx_q == IDX_WIDTH'(MASK_WIDTH - 1));
        y_ext_s  = {{(CNT_WIDTH-1){1'b0}}, in_y};
    end

    // Next-state and word-register update for the FILL/HOLD machine.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        count_d = count_q;
        nbits_d = nbits_q;
        last_d  = last_q;
        case (state_q)
            FILL: begin
                if (accept_s) begin
                    mask_d[idx_q] = in_y;
                    count_d       = count_q + y_ext_s;
                    nbits_d       = CNT_WIDTH'(idx_q) + CNT_WIDTH'(1);
                    if (at_top_s || in_last) begin
                        state_d = HOLD;
                        last_d  = in_last;
                        idx_d   = '0;
                    end else begin
                        idx_d   = idx_q + IDX_WIDTH'(1);
                    end
                end else begin
                    state_d = FILL;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    // Held word leaves; any beat this cycle opens a fresh word at bit 0.
                    mask_d  = '0;
                    count_d = '0;
                    nbits_d = '0;
                    last_d  = 1'b0;
                    idx_d   = '0;
                    state_d = FILL;
                    if (accept_s) begin
                        mask_d[0] = in_y;
                        count_d   = y_ext_s;
                        nbits_d   = CNT_WIDTH'(1);
                        if (in_last) begin
                            state_d = HOLD;
                            last_d  = 1'b1;
                        end else begin
                            idx_d   = IDX_WIDTH'(1);
                        end
                    end else begin
                        state_d = FILL;
                    end
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = FILL;
                idx_d   = '0;
                mask_d  = '0;
                count_d = '0;
                nbits_d = '0;
                last_d  = 1'b0;
            end
        endcase
    end

    // State and word registers; reset discards any partial or held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            idx_q   <= '0;
            mask_q  <= '0;
            count_q <= '0;
            nbits_q <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
            count_q <= count_d;
            nbits_q <= nbits_d;
            last_q  <= last_d;
        end
    end

    // Outputs come straight from flops.
    always_comb begin
        out_valid = (state_q == HOLD);
        out_mask  = mask_q;
        out_count = count_q;
        out_nbits = nbits_q;
        out_last  = last_q;
    end

endmodule

// File: tb/tb_lt_mask_packer.sv
// Directed bench for lt_mask_packer with hand-computed expected words.
module tb_lt_mask_packer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_y;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_mask;
    logic [4:0]  out_count;
    logic [4:0]  out_nbits;
    logic        out_last;

    int n_checks;
    int n_pass;

    lt_mask_packer #(.MASK_WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_y      (in_y),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mask  (out_mask),
        .out_count (out_count),
        .out_nbits (out_nbits),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic v, input logic [15:0] m,
                              input logic [4:0] c, input logic [4:0] nb, input logic l);
        check_val({tag, ".valid"}, 64'(out_valid), 64'(v));
        check_val({tag, ".mask"},  64'(out_mask),  64'(m));
        check_val({tag, ".count"}, 64'(out_count), 64'(c));
        check_val({tag, ".nbits"}, 64'(out_nbits), 64'(nb));
        check_val({tag, ".last"},  64'(out_last),  64'(l));
    endtask

    // One accepted beat; returns #1 after the capturing edge.
    task automatic beat(input logic y, input logic last);
        in_valid = 1'b1;
        in_y     = y;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_y     = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic signed [15:0] a;
        logic signed [15:0] b;
        logic               y;
        int                 words;
        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_y      = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Reset state
        #3;
        check_word("reset", 1'b0, 16'h0000, 5'd0, 5'd0, 1'b0);
        check_val("reset.in_ready", 64'(in_ready), 64'd1);
        #9;
        rst_n = 1'b1;
        idle(1);

        // Reset mid-word
        repeat (5) beat(1'b1, 1'b0);
        check_word("partial", 1'b0, 16'h001F, 5'd5, 5'd5, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_word("midreset", 1'b0, 16'h0000, 5'd0, 5'd0, 1'b0);
        check_val("midreset.in_ready", 64'(in_ready), 64'd1);
        #3;
        rst_n = 1'b1;
        idle(1);

        // Full word 1,0,1,0,...
        for (int i = 0; i < 15; i++) beat((i % 2) == 0, 1'b0);
        check_val("full.pre_valid", 64'(out_valid), 64'd0);
        beat(1'b0, 1'b0);
        check_word("full", 1'b1, 16'h5555, 5'd8, 5'd16, 1'b0);
        idle(1);
        check_word("full.after", 1'b0, 16'h0000, 5'd0, 5'd0, 1'b0);

        // Early close
        beat(1'b1, 1'b0);
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b1);
        check_word("early", 1'b1, 16'h0003, 5'd2, 5'd3, 1'b1);
        idle(1);

        // in_last at idx 0
        beat(1'b1, 1'b1);
        check_word("single", 1'b1, 16'h0001, 5'd1, 5'd1, 1'b1);
        idle(1);

        // Backpressure
        out_ready = 1'b0;
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b1);
        check_word("bp.close", 1'b1, 16'h0001, 5'd1, 5'd2, 1'b1);
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_y     = 1'b0;
            in_last  = 1'b1;
            @(negedge clk);
            check_val("bp.in_ready", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
            check_word("bp.hold", 1'b1, 16'h0001, 5'd1, 5'd2, 1'b1);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_y      = 1'b1;
        in_last   = 1'b0;
        @(negedge clk);
        check_val("bp.release_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_y     = 1'b0;
        check_word("bp.newword", 1'b0, 16'h0001, 5'd1, 5'd1, 1'b0);
        beat(1'b0, 1'b1);
        check_word("bp.second", 1'b1, 16'h0001, 5'd1, 5'd2, 1'b1);
        idle(1);

        // Streaming 48 beats from the signed compare
        words = 0;
        for (int j = 0; j < 48; j++) begin
            if ((j % 2) == 1) begin
                a = -16'sd3;
                b = 16'sd2;
            end else begin
                a = 16'sd5;
                b = -16'sd7;
            end
            y        = (a < b);
            in_valid = 1'b1;
            in_y     = y;
            in_last  = 1'b0;
            @(negedge clk);
            check_val("stream.in_ready", 64'(in_ready), 64'd1);
            @(posedge clk);
            #1;
            check_val("stream.valid", 64'(out_valid), 64'((j % 16) == 15));
            if (out_valid) begin
                words++;
                check_word("stream.word", 1'b1, 16'hAAAA, 5'd8, 5'd16, 1'b0);
            end
        end
        in_valid = 1'b0;
        in_y     = 1'b0;
        idle(1);
        check_val("stream.words", 64'(words), 64'd3);
        check_val("stream.drained", 64'(out_valid), 64'd0);

        // Boundary: in_last on the final bit
        for (int i = 0; i < 15; i++) beat(1'b1, 1'b0);
        beat(1'b1, 1'b1);
        check_word("boundary", 1'b1, 16'hFFFF, 5'd16, 5'd16, 1'b1);
        idle(1);
        check_val("boundary.no_extra1", 64'(out_valid), 64'd0);
        idle(1);
        check_val("boundary.no_extra2", 64'(out_valid), 64'd0);
        check_val("boundary.nbits_clear", 64'(out_nbits), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
